ex_muldiv: RTL and testbench

Iterative multiply/divide unit with HI/LO registers, living in the EX stage beside the ALU. It consumes the operands and decoded mult/div control that the ID/EX pipeline register presents. It runs MULT/MULTU/DIV/DIVU over 33 cycles in the background and requests a pipeline stall only when a later HI/LO-dependent instruction reaches EX before the result is ready. It also services MTHI/MTLO writes, and feeds HI/LO to the EX result mux for MFHI/MFLO.

---
 rtl/ex_muldiv.sv | 141 ++++++++++++++
 tb/tb_ex_muldiv.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO registers for the EX stage.
// Runs in the background for 33 cycles; stalls only HI/LO-dependent instructions.
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        hilo_use,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]     state, state_next;
    logic           busy_next;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [2*W-1:0] acc;
    logic           neg_q, neg_r;

    logic           signed_op;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic           div_ok;
    logic [2*W-1:0] calc_next, prod_fix;
    logic [W-1:0]   fix_hi, fix_lo;

    assign stall = busy & hilo_use;

    // Operand conditioning at issue: signed ops work on magnitudes
    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && src_a[W-1]) ? W'(-src_a) : src_a;
    assign abs_b     = (signed_op && src_b[W-1]) ? W'(-src_b) : src_b;

    // One iteration: shift-add multiply (LSB first) or restoring divide (MSB first)
    assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    assign div_shift = acc[2*W-1:W-1];
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ok    = ~div_diff[W];
    assign calc_next = op_q[1]
                     ? {(div_ok ? div_diff[W-1:0] : div_shift[W-1:0]), acc[W-2:0], div_ok}
                     : {mul_sum, acc[W-1:1]};

    // Sign correction; divide-by-zero forces an all-ones quotient regardless of sign
    assign prod_fix = neg_q ? (2*W)'(-acc) : acc;
    always_comb begin
        fix_hi = prod_fix[2*W-1:W];
        fix_lo = prod_fix[W-1:0];
        if (op_q[1]) begin
            fix_hi = neg_r ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
            if (b_q == '0)
                fix_lo = '1;
            else
                fix_lo = neg_q ? W'(-acc[W-1:0]) : acc[W-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_CALC;
            S_CALC:  if (cnt == CW'(W - 1)) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush)
            state_next = S_IDLE;
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                        if (start) begin
                            op_q  <= op;
                            a_q   <= abs_a;
                            b_q   <= abs_b;
                            neg_q <= signed_op & (src_a[W-1] ^ src_b[W-1]);
                            neg_r <= signed_op & src_a[W-1];
                            cnt   <= '0;
                            acc   <= {{W{1'b0}}, (op[1] ? abs_a : abs_b)};
                        end
                    end
                    S_CALC: begin
                        acc <= calc_next;
                        cnt <= CW'(cnt + CW'(1));
                    end
                    S_FIX: begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: arithmetic results, timing, stall, flush and reset.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        hi_we, lo_we, hilo_use, flush;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    ex_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hilo_use(hilo_use), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op and watch 36 cycles: busy for 33, single done pulse after E33
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int busy_n, done_n, done_at, stall_n;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; src_a = '0; src_b = '0;
        busy_n = 0; done_n = 0; done_at = -1; stall_n = 0;
        for (int k = 0; k < 36; k++) begin
            if (k > 0) @(negedge clk);
            busy_n  += int'(busy);
            stall_n += int'(stall);
            if (done) begin
                done_n++;
                done_at = k;
            end
        end
        chk({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
        chk({tag, " done_count"}, 64'(done_n), 64'd1);
        chk({tag, " done_at"}, 64'(done_at), 64'd33);
        chk({tag, " no_stall"}, 64'(stall_n), 64'd0);
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        int s0, sn, dn;
        reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        wdata = '0; hi_we = 1'b0; lo_we = 1'b0; hilo_use = 1'b1; flush = 1'b0;
        #12;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset = 1'b0; hilo_use = 1'b0;

        run_op("mult",  2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", 2'b01, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // Stall only while a HI/LO user sits in EX during busy
        @(negedge clk);
        op = 2'b00; src_a = 32'd5; src_b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s0 = 0; sn = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            s0 += int'(stall);
        end
        hilo_use = 1'b1;
        for (int k = 5; k <= 32; k++) begin
            @(negedge clk);
            sn += int'(stall);
        end
        @(negedge clk);
        chk("stall idle_use", 64'(s0), 64'd0);
        chk("stall held", 64'(sn), 64'd28);
        chk("stall dropped", 64'(stall), 64'd0);
        chk("stall done", 64'(done), 64'd1);
        chk("mult5x7 hi", 64'(hi), 64'd0);
        chk("mult5x7 lo", 64'(lo), 64'd35);
        hilo_use = 1'b0;

        // MTHI / MTLO
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h000055AA;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h00001234;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mthi", 64'(hi), 64'h55AA);
        chk("mtlo", 64'(lo), 64'h1234);

        // Flush a DIVU at E10
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 9; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        dn = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            dn += int'(done);
        end
        chk("flush no_done", 64'(dn), 64'd0);
        chk("flush lo", 64'(lo), 64'h1234);
        chk("flush hi", 64'(hi), 64'h55AA);

        // Asynchronous reset mid-CALC
        op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; hilo_use = 1'b1;
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst hi", 64'(hi), 64'd0);
        chk("async_rst lo", 64'(lo), 64'd0);
        chk("async_rst busy", 64'(busy), 64'd0);
        chk("async_rst stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset = 1'b0; hilo_use = 1'b0;

        run_op("mult_after_rst", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
